// File: rtl/tns_enc_22_seq.sv
// Sequential greedy encoder: binary word -> 22-bit TNS codeword, one weight per cycle
// from bit 21 down to bit 0, with a one-word output holding register.

`ifndef BLEN08_C
`define BLEN08_C 20
`endif
`ifndef TNS08_C
`define TNS08_C 410744
`endif
`ifndef TNS07_A
`define TNS07_A 223317
`endif
`ifndef TNS07_B
`define TNS07_B 121415
`endif
`ifndef TNS07_C
`define TNS07_C 66012
`endif
`ifndef TNS06_A
`define TNS06_A 35890
`endif
`ifndef TNS06_B
`define TNS06_B 19513
`endif
`ifndef TNS06_C
`define TNS06_C 10609
`endif
`ifndef TNS05_A
`define TNS05_A 5768
`endif
`ifndef TNS05_B
`define TNS05_B 3136
`endif
`ifndef TNS05_C
`define TNS05_C 1705
`endif
`ifndef TNS04_A
`define TNS04_A 927
`endif
`ifndef TNS04_B
`define TNS04_B 504
`endif
`ifndef TNS04_C
`define TNS04_C 274
`endif
`ifndef TNS03_A
`define TNS03_A 149
`endif
`ifndef TNS03_B
`define TNS03_B 81
`endif
`ifndef TNS03_C
`define TNS03_C 44
`endif
`ifndef TNS02_A
`define TNS02_A 24
`endif
`ifndef TNS02_B
`define TNS02_B 13
`endif
`ifndef TNS02_C
`define TNS02_C 7
`endif
`ifndef TNS01_A
`define TNS01_A 4
`endif
`ifndef TNS01_B
`define TNS01_B 2
`endif
`ifndef TNS01_C
`define TNS01_C 1
`endif

// Handshakes: a word moves on any rising edge where valid & ready are both 1.
// Valid never waits on ready; din_ready depends only on the FSM state.
module tns_enc_22_seq #(
  parameter int DW = `BLEN08_C,
  parameter int CW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [DW-1:0] din,
  output logic          code_valid,
  input  logic          code_ready,
  output logic [CW-1:0] code_out,
  output logic          code_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] residual_q, residual_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] work_q, work_d;
  logic          code_valid_q, code_valid_d;
  logic [CW-1:0] code_out_q, code_out_d;
  logic          code_err_q, code_err_d;

  logic [DW-1:0] w_cur;
  logic          take_bit;
  logic [DW-1:0] res_next;
  logic [CW-1:0] work_next;

  always_comb begin
    w_cur = '0;
    case (idx_q)
      5'd21: w_cur = DW'(`TNS08_C);
      5'd20: w_cur = DW'(`TNS07_A);
      5'd19: w_cur = DW'(`TNS07_B);
      5'd18: w_cur = DW'(`TNS07_C);
      5'd17: w_cur = DW'(`TNS06_A);
      5'd16: w_cur = DW'(`TNS06_B);
      5'd15: w_cur = DW'(`TNS06_C);
      5'd14: w_cur = DW'(`TNS05_A);
      5'd13: w_cur = DW'(`TNS05_B);
      5'd12: w_cur = DW'(`TNS05_C);
      5'd11: w_cur = DW'(`TNS04_A);
      5'd10: w_cur = DW'(`TNS04_B);
      5'd9:  w_cur = DW'(`TNS04_C);
      5'd8:  w_cur = DW'(`TNS03_A);
      5'd7:  w_cur = DW'(`TNS03_B);
      5'd6:  w_cur = DW'(`TNS03_C);
      5'd5:  w_cur = DW'(`TNS02_A);
      5'd4:  w_cur = DW'(`TNS02_B);
      5'd3:  w_cur = DW'(`TNS02_C);
      5'd2:  w_cur = DW'(`TNS01_A);
      5'd1:  w_cur = DW'(`TNS01_B);
      5'd0:  w_cur = DW'(`TNS01_C);
      default: w_cur = '0;
    endcase
  end

  // Greedy step for the current weight; the subtraction only happens when it cannot underflow.
  always_comb begin
    take_bit  = (residual_q >= w_cur);
    res_next  = take_bit ? (residual_q - w_cur) : residual_q;
    work_next = work_q;
    if (idx_q < 5'(CW)) begin
      work_next[idx_q] = take_bit;
    end
  end

  always_comb begin
    state_d      = state_q;
    residual_d   = residual_q;
    idx_d        = idx_q;
    work_d       = work_q;
    code_valid_d = code_valid_q;
    code_out_d   = code_out_q;
    code_err_d   = code_err_q;

    if (code_valid_q && code_ready) begin
      code_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          residual_d = din;
          idx_d      = 5'(CW - 1);
          work_d     = '0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        if (idx_q != 5'd0) begin
          residual_d = res_next;
          work_d     = work_next;
          idx_d      = idx_q - 5'd1;
        end else if (!code_valid_q || code_ready) begin
          // Load wins over drain, so a simultaneous load/drain keeps code_valid high.
          code_valid_d = 1'b1;
          code_out_d   = work_next;
          code_err_d   = (res_next != '0);
          residual_d   = '0;
          work_d       = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      residual_q   <= '0;
      idx_q        <= '0;
      work_q       <= '0;
      code_valid_q <= 1'b0;
      code_out_q   <= '0;
      code_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      residual_q   <= residual_d;
      idx_q        <= idx_d;
      work_q       <= work_d;
      code_valid_q <= code_valid_d;
      code_out_q   <= code_out_d;
      code_err_q   <= code_err_d;
    end
  end

  assign din_ready  = (state_q == ST_IDLE);
  assign code_valid = code_valid_q;
  assign code_out   = code_out_q;
  assign code_err   = code_err_q;

endmodule
